// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler: after SRAM init, each begin_lookup scans a snapshot of
// the key mask and maps pressed keys onto audio channels. Each mapping is an
// ld_addr pulse, SRAM_LAT wait cycles, then an ld_sound pulse. Leftover channels
// are loaded with silence (sound_num 4'hF).
// Optional feature: define AUDIO_SCHED_RR_EN to rotate the scan start point
// after an overflowing scan, so high-index keys are not starved.
module audio_voice_scheduler #(
    parameter int unsigned NUM_KEYS = 12,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SRAM_LAT = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic                INIT_FINISH,
    input  logic                begin_lookup,
    input  logic [NUM_KEYS-1:0] key_mask,
    output logic                INIT,
    output logic [NUM_CH-1:0]   ld_addr,
    output logic [NUM_CH-1:0]   ld_sound,
    output logic [3:0]          sound_num,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                lookup_drop
);

    localparam int unsigned CH_W  = $clog2(NUM_CH + 1);
    localparam int unsigned KW    = 4;
    localparam int unsigned LAT_W = 3;

    typedef enum logic [3:0] {
        WAIT_START, SEND_INIT, WAIT_ACK, STANDBY,
        CHECK, ISSUE, WAIT_SRAM, LOAD, FILL, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d, k_step;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                ovf_d;
    logic                pressed, all_vis, adv;
    logic                init_d, busy_d, done_d;
    logic [NUM_CH-1:0]   ld_addr_d, ld_sound_d;
    logic [3:0]          sound_num_d;
`ifdef AUDIO_SCHED_RR_EN
    logic [KW-1:0]       vis_q, vis_d;
    logic [KW-1:0]       rr_base_q, rr_base_d;
`endif

    // Drop indication is tied to the request itself, so it is flagged in the same cycle
    assign lookup_drop = begin_lookup & busy;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ch_d      = ch_q;
        snap_d    = snap_q;
        lat_d     = lat_q;
        ovf_d     = overflow;
        adv       = 1'b0;
        pressed   = 1'b0;
`ifdef AUDIO_SCHED_RR_EN
        vis_d     = vis_q;
        rr_base_d = rr_base_q;
        k_step    = (k_q == KW'(NUM_KEYS - 1)) ? '0 : k_q + KW'(1);
        all_vis   = (vis_q == KW'(NUM_KEYS));
`else
        k_step    = k_q + KW'(1);
        all_vis   = (k_q == KW'(NUM_KEYS));
`endif
        // key index k maps to the MSB-first bit of the snapshot
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (k_q == KW'(i)) pressed = snap_q[NUM_KEYS-1-i];
        end

        unique case (state_q)
            WAIT_START: if (Start) state_d = SEND_INIT;
            SEND_INIT:  state_d = WAIT_ACK;
            WAIT_ACK:   if (INIT_FINISH) state_d = STANDBY;
            STANDBY: begin
                if (begin_lookup) begin
                    state_d = CHECK;
                    snap_d  = key_mask;
                    ch_d    = '0;
                    ovf_d   = 1'b0;
`ifdef AUDIO_SCHED_RR_EN
                    k_d     = rr_base_q;
                    vis_d   = '0;
`else
                    k_d     = '0;
`endif
                end
            end
            CHECK: begin
                if (all_vis) begin
                    state_d = (ch_q < CH_W'(NUM_CH)) ? FILL : DONE;
                end else if (pressed && (ch_q == CH_W'(NUM_CH))) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else if (pressed) begin
                    state_d = ISSUE;
                end else begin
                    adv = 1'b1;
                end
            end
            ISSUE: begin
                lat_d   = '0;
                state_d = WAIT_SRAM;
            end
            WAIT_SRAM: begin
                if (lat_q == LAT_W'(SRAM_LAT - 1)) state_d = LOAD;
                else                               lat_d   = lat_q + LAT_W'(1);
            end
            LOAD: begin
                ch_d    = ch_q + CH_W'(1);
                adv     = 1'b1;
                state_d = CHECK;
            end
            FILL: begin
                ch_d = ch_q + CH_W'(1);
                if (ch_q == CH_W'(NUM_CH - 1)) state_d = DONE;
            end
            DONE: begin
`ifdef AUDIO_SCHED_RR_EN
                // k still points at the first pressed key that found no channel
                if (overflow) rr_base_d = k_q;
`endif
                state_d = STANDBY;
            end
            default: state_d = WAIT_START;
        endcase

        if (adv) begin
            k_d = k_step;
`ifdef AUDIO_SCHED_RR_EN
            vis_d = vis_q + KW'(1);
`endif
        end

        // Outputs are decoded from the next state so they register alongside it
        init_d = (state_d == SEND_INIT);
        done_d = (state_d == DONE);
        busy_d = (state_d == CHECK) || (state_d == ISSUE) || (state_d == WAIT_SRAM) ||
                 (state_d == LOAD) || (state_d == FILL) || (state_d == DONE);
        for (int i = 0; i < NUM_CH; i++) begin
            ld_addr_d[i]  = (state_d == ISSUE) && (ch_d == CH_W'(i));
            ld_sound_d[i] = ((state_d == LOAD) || (state_d == FILL)) && (ch_d == CH_W'(i));
        end
        sound_num_d = ((state_d == ISSUE) || (state_d == WAIT_SRAM) || (state_d == LOAD))
                      ? k_d : 4'hF;
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= WAIT_START;
            k_q       <= '0;
            ch_q      <= '0;
            snap_q    <= '0;
            lat_q     <= '0;
            overflow  <= 1'b0;
            INIT      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ld_addr   <= '0;
            ld_sound  <= '0;
            sound_num <= 4'hF;
`ifdef AUDIO_SCHED_RR_EN
            vis_q     <= '0;
            rr_base_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ch_q      <= ch_d;
            snap_q    <= snap_d;
            lat_q     <= lat_d;
            overflow  <= ovf_d;
            INIT      <= init_d;
            busy      <= busy_d;
            done      <= done_d;
            ld_addr   <= ld_addr_d;
            ld_sound  <= ld_sound_d;
            sound_num <= sound_num_d;
`ifdef AUDIO_SCHED_RR_EN
            vis_q     <= vis_d;
            rr_base_q <= rr_base_d;
`endif
        end
    end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Bench for audio_voice_scheduler: directed and random scans compared cycle by
// cycle against a per-key cost model of the scan (honours AUDIO_SCHED_RR_EN).
module tb_audio_voice_scheduler;

    localparam int unsigned NUM_KEYS = 12;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned SRAM_LAT = 2;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        INIT_FINISH;
    logic        begin_lookup;
    logic [11:0] key_mask;
    logic        INIT;
    logic [3:0]  ld_addr;
    logic [3:0]  ld_sound;
    logic [3:0]  sound_num;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        lookup_drop;

    audio_voice_scheduler #(
        .NUM_KEYS(NUM_KEYS), .NUM_CH(NUM_CH), .SRAM_LAT(SRAM_LAT)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .INIT_FINISH(INIT_FINISH),
        .begin_lookup(begin_lookup), .key_mask(key_mask), .INIT(INIT),
        .ld_addr(ld_addr), .ld_sound(ld_sound), .sound_num(sound_num),
        .busy(busy), .done(done), .overflow(overflow), .lookup_drop(lookup_drop)
    );

    typedef struct packed {
        logic       dn;
        logic [3:0] la;
        logic [3:0] ls;
        logic [3:0] sn;
    } rec_t;

    rec_t exp_q[$];
    logic exp_ov;
    logic prev_ov;
    int   model_rr;
    int   next_rr;
    int   errors;
    int   checks;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(logic i, logic b, logic d, logic o, logic dr,
                                        logic [3:0] la, logic [3:0] ls, logic [3:0] sn);
        return {15'd0, i, b, d, o, dr, la, ls, sn};
    endfunction

    function automatic logic [31:0] obs();
        return pk(INIT, busy, done, overflow, lookup_drop, ld_addr, ld_sound, sound_num);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    function automatic rec_t mk(logic dn, logic [3:0] la, logic [3:0] ls, logic [3:0] sn);
        rec_t r;
        r.dn = dn; r.la = la; r.ls = ls; r.sn = sn;
        return r;
    endfunction

    // Expected busy-window timeline: unpressed key costs one check cycle, a
    // served key costs check+issue+latency+load, then silence fills and done.
    task automatic build_expect(input logic [11:0] mask);
        int   base, ch, k;
        logic pressed;
        exp_q.delete();
        exp_ov = 1'b0;
        ch = 0;
`ifdef AUDIO_SCHED_RR_EN
        base = model_rr;
`else
        base = 0;
`endif
        next_rr = model_rr;
        for (int v = 0; v < NUM_KEYS; v++) begin
            k = (base + v) % NUM_KEYS;
            pressed = mask[NUM_KEYS-1-k];
            exp_q.push_back(mk(1'b0, 4'h0, 4'h0, 4'hF));
            if (pressed) begin
                if (ch == NUM_CH) begin
                    exp_ov  = 1'b1;
                    next_rr = k;
                    break;
                end
                exp_q.push_back(mk(1'b0, 4'(1 << ch), 4'h0, 4'(k)));
                for (int w = 0; w < SRAM_LAT; w++) exp_q.push_back(mk(1'b0, 4'h0, 4'h0, 4'(k)));
                exp_q.push_back(mk(1'b0, 4'h0, 4'(1 << ch), 4'(k)));
                ch++;
            end
        end
        if (!exp_ov) begin
            exp_q.push_back(mk(1'b0, 4'h0, 4'h0, 4'hF));
            for (int c = ch; c < NUM_CH; c++) exp_q.push_back(mk(1'b0, 4'h0, 4'(1 << c), 4'hF));
        end
        exp_q.push_back(mk(1'b1, 4'h0, 4'h0, 4'hF));
    endtask

    task automatic run_scan(input string name, input logic [11:0] mask,
                            input int drop_at, input bit toggle);
        rec_t r;
        build_expect(mask);
        step(); key_mask = mask; begin_lookup = 1'b1;
        sample();
        check_val({name, "_accept"}, obs(), pk(0, 0, 0, prev_ov, 0, 4'h0, 4'h0, 4'hF));
        for (int i = 0; i < exp_q.size(); i++) begin
            r = exp_q[i];
            step();
            begin_lookup = (i == drop_at);
            if (toggle) key_mask = 12'($urandom);
            sample();
            check_val($sformatf("%s_c%0d", name, i), obs(),
                      pk(0, 1, r.dn, r.dn ? exp_ov : 1'b0, (i == drop_at), r.la, r.ls, r.sn));
        end
        step(); begin_lookup = 1'b0;
        sample();
        check_val({name, "_idle"}, obs(), pk(0, 0, 0, exp_ov, 0, 4'h0, 4'h0, 4'hF));
        prev_ov = exp_ov;
`ifdef AUDIO_SCHED_RR_EN
        model_rr = next_rr;
`endif
    endtask

    task automatic do_init();
        int ninit;
        step(); Start = 1'b1;
        sample();
        step(); Start = 1'b0;
        sample();
        check_val("init_pulse", 32'(INIT), 32'd1);
        ninit = 0;
        for (int i = 0; i < 7; i++) begin
            step(); INIT_FINISH = (i == 4);
            sample();
            ninit += int'(INIT);
        end
        step(); INIT_FINISH = 1'b0;
        sample();
        check_val("init_single", 32'(ninit), 32'd0);
        check_val("standby", obs(), pk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF));
    endtask

    initial begin
        logic [11:0] m;
        errors = 0; checks = 0; model_rr = 0; next_rr = 0; prev_ov = 1'b0;
        Reset_n = 1'b0; Start = 1'b0; INIT_FINISH = 1'b0; begin_lookup = 1'b0; key_mask = '0;
        step(); step();
        sample();
        check_val("reset", obs(), pk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF));
        Reset_n = 1'b1;

        // begin_lookup is meaningless before init
        step(); begin_lookup = 1'b1;
        sample();
        step(); begin_lookup = 1'b0;
        sample();
        check_val("pre_init_lookup", obs(), pk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF));
        do_init();

        // Reset while waiting on SRAM: the pending ld_sound must never appear
        step(); key_mask = 12'h800; begin_lookup = 1'b1;
        sample();
        step(); begin_lookup = 1'b0;
        sample();
        step();
        sample();
        check_val("rst_issue", obs(), pk(0, 1, 0, 0, 0, 4'h1, 4'h0, 4'h0));
        step(); Reset_n = 1'b0;
        sample();
        check_val("rst_wait", obs(), pk(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));
        step(); Reset_n = 1'b1;
        sample();
        check_val("rst_mid", obs(), pk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF));
        for (int i = 0; i < SRAM_LAT + 3; i++) begin
            step();
            sample();
            check_val($sformatf("rst_quiet%0d", i), obs(), pk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF));
        end
        model_rr = 0; prev_ov = 1'b0;
        do_init();

        // Directed scans
        run_scan("key0",  12'h800, -1, 1'b0);
        run_scan("empty", 12'h000, -1, 1'b0);
        check_val("empty_len", 32'(exp_q.size()), 32'd18);
        run_scan("full1", 12'hFFF, -1, 1'b0);
        run_scan("full2", 12'hFFF, -1, 1'b0);
        run_scan("drop",  12'h5A3, 6, 1'b1);
        run_scan("dropd", 12'h0F0, 1000, 1'b0);
        run_scan("dropl", 12'h00F, exp_q.size() + 1, 1'b0);

        // Random scans with random drops and mid-scan key_mask churn
        for (int n = 0; n < 24; n++) begin
            m = 12'($urandom);
            if (n % 3 == 0) m = m & 12'($urandom);
            run_scan($sformatf("rnd%0d", n), m, int'($urandom_range(0, 30)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
